// File: rtl/shadow_config_mem_pkg.sv
// Shared types and elaboration helpers for the shadow configuration memory.
package shadow_config_mem_pkg;

   // Two-phase controller: accept writes, or copy shadow into active.
   typedef enum logic {
      S_IDLE   = 1'b0,
      S_COMMIT = 1'b1
   } state_e;

   // Number of frames needed to carry nbits configuration bits.
   function automatic int calc_nframes(input int nbits, input int fbits);
      return (nbits + fbits - 1) / fbits;
   endfunction

   // ConfigBits index fed by frame f, frame bit b. Negative means the bit
   // falls below the bottom of the configuration vector (unused tail bits).
   function automatic int cfg_index(input int f, input int b, input int fbits, input int nbits);
      return nbits - 1 - (f * fbits + fbits - 1 - b);
   endfunction

endpackage

// File: rtl/config_frame_slice.sv
// One configuration frame: shadow register written by the host, active
// register loaded from shadow on commit. Unused bits are masked at write.
module config_frame_slice #(
   parameter int                         FrameBitsPerRow = 32,
   parameter logic [FrameBitsPerRow-1:0] VALID_MASK      = '1
) (
   input  logic                       i_clk,
   input  logic                       i_resetn,
   input  logic                       i_wr_en,
   input  logic [FrameBitsPerRow-1:0] i_wr_data,
   input  logic                       i_load,
   output logic [FrameBitsPerRow-1:0] o_shadow,
   output logic [FrameBitsPerRow-1:0] o_active
);

   logic [FrameBitsPerRow-1:0] r_shadow;
   logic [FrameBitsPerRow-1:0] r_active;

   // Shadow takes masked host data; active takes the shadow on load.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_shadow <= '0;
         r_active <= '0;
      end else begin
         if (i_wr_en) r_shadow <= i_wr_data & VALID_MASK;
         if (i_load)  r_active <= r_shadow;
      end
   end

   assign o_shadow = r_shadow;
   assign o_active = r_active;

endmodule

// File: rtl/shadow_config_mem.sv
// Double-buffered configuration memory: frames are written into a shadow
// copy, and a commit (only once every frame has been written) copies the
// whole shadow into the active copy that drives ConfigBits.
module shadow_config_mem
   import shadow_config_mem_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NoConfigBits    = 74
) (
   input  logic                               CLK,
   input  logic                               resetn,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [$clog2(MaxFramesPerCol)-1:0] wr_frame,
   input  logic [FrameBitsPerRow-1:0]         FrameData,
   input  logic                               commit,
   output logic                               commit_done,
   output logic                               commit_err,
   output logic                               wr_err,
   input  logic                               rd_req,
   input  logic [$clog2(MaxFramesPerCol)-1:0] rd_frame,
   input  logic                               rd_shadow,
   output logic                               rd_valid,
   output logic [FrameBitsPerRow-1:0]         rd_data,
   output logic [NoConfigBits-1:0]            ConfigBits,
   output logic [NoConfigBits-1:0]            ConfigBits_N
);

   localparam int FW      = $clog2(MaxFramesPerCol);
   localparam int NFRAMES = calc_nframes(NoConfigBits, FrameBitsPerRow);

   if (NFRAMES > MaxFramesPerCol) begin : g_bad_cfg
      $error("shadow_config_mem: NoConfigBits needs more frames than MaxFramesPerCol");
   end

   state_e                                   r_state;
   state_e                                   w_state_nxt;
   logic [NFRAMES-1:0]                       r_mask;
   logic [NFRAMES-1:0]                       w_wr_sel;
   logic [NFRAMES-1:0]                       w_rd_sel;
   logic [NFRAMES-1:0][FrameBitsPerRow-1:0]  w_shadow;
   logic [NFRAMES-1:0][FrameBitsPerRow-1:0]  w_active;
   logic                                     w_idle;
   logic                                     w_hs;
   logic                                     w_wr_hit;
   logic                                     w_wr_ok;
   logic                                     w_complete;
   logic                                     w_cerr;
   logic                                     w_copy;
   logic [FrameBitsPerRow-1:0]               w_rd_word;
   logic [NoConfigBits-1:0]                  w_cfg;
   logic                                     r_commit_done;
   logic                                     r_commit_err;
   logic                                     r_wr_err;
   logic                                     r_rd_valid;
   logic [FrameBitsPerRow-1:0]               r_rd_data;

   assign w_idle   = (r_state == S_IDLE);
   assign w_hs     = wr_valid & w_idle;
   assign w_wr_hit = |w_wr_sel;
   assign w_wr_ok  = w_hs & w_wr_hit;
   // A frame written in the same cycle as commit counts toward completeness.
   assign w_complete = &(r_mask | (w_wr_ok ? w_wr_sel : '0));

   // One-hot frame decode; an index beyond the last frame selects nothing.
   always_comb begin
      w_wr_sel = '0;
      w_rd_sel = '0;
      for (int f = 0; f < NFRAMES; f++) begin
         w_wr_sel[f] = (wr_frame == FW'(f));
         w_rd_sel[f] = (rd_frame == FW'(f));
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM next state: commit only with a full set of frames, otherwise refuse.
   always_comb begin
      w_state_nxt = r_state;
      w_cerr      = 1'b0;
      w_copy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (commit) begin
               if (w_complete) w_state_nxt = S_COMMIT;
               else            w_cerr      = 1'b1;
            end
         end
         S_COMMIT: begin
            w_copy      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Track which frames were written since the last commit.
   always_ff @(posedge CLK) begin
      if (!resetn)      r_mask <= '0;
      else if (w_copy)  r_mask <= '0;
      else if (w_wr_ok) r_mask <= r_mask | w_wr_sel;
   end

   // Status pulses, each one cycle after its cause.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         r_commit_done <= 1'b0;
         r_commit_err  <= 1'b0;
         r_wr_err      <= 1'b0;
      end else begin
         r_commit_done <= w_copy;
         r_commit_err  <= w_cerr;
         r_wr_err      <= w_hs & ~w_wr_hit;
      end
   end

   // Readback mux; out-of-range frames read as zero.
   always_comb begin
      w_rd_word = '0;
      for (int f = 0; f < NFRAMES; f++) begin
         if (w_rd_sel[f]) w_rd_word = rd_shadow ? w_shadow[f] : w_active[f];
      end
   end

   // Registered readback; sees pre-edge shadow, so a same-cycle write reads old.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= rd_req;
         if (rd_req) r_rd_data <= w_rd_word;
      end
   end

   for (genvar f = 0; f < NFRAMES; f++) begin : g_frame
      localparam int NV = (NoConfigBits - f * FrameBitsPerRow < FrameBitsPerRow) ?
                          (NoConfigBits - f * FrameBitsPerRow) : FrameBitsPerRow;
      localparam logic [FrameBitsPerRow-1:0] MSK = ~({FrameBitsPerRow{1'b1}} >> NV);

      config_frame_slice #(
         .FrameBitsPerRow(FrameBitsPerRow),
         .VALID_MASK     (MSK)
      ) u_slice (
         .i_clk    (CLK),
         .i_resetn (resetn),
         .i_wr_en  (w_wr_ok & w_wr_sel[f]),
         .i_wr_data(FrameData),
         .i_load   (w_copy),
         .o_shadow (w_shadow[f]),
         .o_active (w_active[f])
      );

      // Frame bits that land inside the configuration vector.
      for (genvar b = 0; b < FrameBitsPerRow; b++) begin : g_bit
         if (cfg_index(f, b, FrameBitsPerRow, NoConfigBits) >= 0) begin : g_map
            assign w_cfg[cfg_index(f, b, FrameBitsPerRow, NoConfigBits)] = w_active[f][b];
         end
      end
   end

   assign wr_ready     = w_idle;
   assign commit_done  = r_commit_done;
   assign commit_err   = r_commit_err;
   assign wr_err       = r_wr_err;
   assign rd_valid     = r_rd_valid;
   assign rd_data      = r_rd_data;
   assign ConfigBits   = w_cfg;
   assign ConfigBits_N = ~w_cfg;

endmodule

// File: tb/tb_shadow_config_mem.sv
// Scoreboard bench for shadow_config_mem: the driver updates a reference
// model (config viewed as one long bit string) and queues expected outputs;
// a negedge monitor pops and compares.
module tb_shadow_config_mem;

   localparam int NCB = 74;
   localparam int FBR = 32;
   localparam int NF  = 3;
   localparam int PAD = NF * FBR - NCB;

   logic           CLK = 1'b0;
   logic           resetn = 1'b0;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [4:0]     wr_frame = '0;
   logic [FBR-1:0] FrameData = '0;
   logic           commit = 1'b0;
   logic           commit_done;
   logic           commit_err;
   logic           wr_err;
   logic           rd_req = 1'b0;
   logic [4:0]     rd_frame = '0;
   logic           rd_shadow = 1'b0;
   logic           rd_valid;
   logic [FBR-1:0] rd_data;
   logic [NCB-1:0] ConfigBits;
   logic [NCB-1:0] ConfigBits_N;

   always #5 CLK = ~CLK;

   shadow_config_mem dut (
      .CLK(CLK), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_frame(wr_frame), .FrameData(FrameData), .commit(commit),
      .commit_done(commit_done), .commit_err(commit_err), .wr_err(wr_err),
      .rd_req(rd_req), .rd_frame(rd_frame), .rd_shadow(rd_shadow),
      .rd_valid(rd_valid), .rd_data(rd_data), .ConfigBits(ConfigBits),
      .ConfigBits_N(ConfigBits_N)
   );

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;
   bit mon_en = 1'b0;

   always @(posedge CLK) ecnt <= ecnt + 1;

   typedef struct { int stamp; logic [FBR-1:0] data; } rd_ev_t;
   rd_ev_t q_rd[$];
   int     q_done[$];
   int     q_cerr[$];
   int     q_werr[$];

   // Reference model: shadow as one NF*FBR string (frame 0 on top),
   // active as the top NCB bits of that string at commit time.
   logic [NF*FBR-1:0] m_sh   = '0;
   logic [NCB-1:0]    m_act  = '0;
   bit   [NF-1:0]     m_mask = '0;
   bit                m_busy = 1'b0;

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   function automatic logic [FBR-1:0] frame_of(input logic [NF*FBR-1:0] v, input int f);
      return v[NF*FBR-1-FBR*f -: FBR];
   endfunction

   // Apply the rules for the coming edge to the model and queue expectations.
   task automatic model_edge();
      int nxt;
      bit [NF-1:0] nm;
      logic [FBR-1:0] d;
      nxt = ecnt + 1;
      if (!resetn) begin
         m_sh = '0; m_act = '0; m_mask = '0; m_busy = 1'b0;
         return;
      end
      if (rd_req) begin
         d = '0;
         if (int'(rd_frame) < NF)
            d = rd_shadow ? frame_of(m_sh, int'(rd_frame))
                          : frame_of({m_act, {PAD{1'b0}}}, int'(rd_frame));
         q_rd.push_back('{nxt, d});
      end
      if (m_busy) begin
         m_act  = m_sh[NF*FBR-1 -: NCB];
         m_mask = '0;
         m_busy = 1'b0;
         q_done.push_back(nxt);
         return;
      end
      nm = m_mask;
      if (wr_valid) begin
         if (int'(wr_frame) < NF) begin
            m_sh[NF*FBR-1-FBR*int'(wr_frame) -: FBR] = FrameData;
            m_sh[PAD-1:0] = '0;
            nm[int'(wr_frame)] = 1'b1;
         end else begin
            q_werr.push_back(nxt);
         end
      end
      m_mask = nm;
      if (commit) begin
         if (&nm) m_busy = 1'b1;
         else     q_cerr.push_back(nxt);
      end
   endtask

   task automatic step(input bit wv, input int wf, input logic [FBR-1:0] wd, input bit cm,
                       input bit rq, input int rf, input bit rs, input bit rn);
      @(negedge CLK);
      #1;
      resetn = rn; wr_valid = wv; wr_frame = 5'(wf); FrameData = wd; commit = cm;
      rd_req = rq; rd_frame = 5'(rf); rd_shadow = rs;
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();                                step(0, 0, '0, 0, 0, 0, 0, 1); endtask
   task automatic wr(input int f, input logic [FBR-1:0] d); step(1, f, d, 0, 0, 0, 0, 1); endtask
   task automatic cm();                                  step(0, 0, '0, 1, 0, 0, 0, 1); endtask
   task automatic rd(input int f, input bit s);          step(0, 0, '0, 0, 1, f, s, 1); endtask
   task automatic rst();                                 step(0, 0, '0, 0, 0, 0, 0, 0); endtask

   // Monitor: every cycle, each output must match presence and content of the queue head.
   always @(negedge CLK) begin
      bit ex;
      rd_ev_t e;
      logic [NCB-1:0] inv;
      if (mon_en) begin
         ex = (q_rd.size() > 0) && (q_rd[0].stamp == ecnt);
         chk("rd_valid", rd_valid, ex);
         if (ex) begin
            e = q_rd.pop_front();
            if (rd_valid) chk("rd_data", rd_data, e.data);
         end
         ex = (q_done.size() > 0) && (q_done[0] == ecnt);
         chk("commit_done", commit_done, ex);
         if (ex) void'(q_done.pop_front());
         ex = (q_cerr.size() > 0) && (q_cerr[0] == ecnt);
         chk("commit_err", commit_err, ex);
         if (ex) void'(q_cerr.pop_front());
         ex = (q_werr.size() > 0) && (q_werr[0] == ecnt);
         chk("wr_err", wr_err, ex);
         if (ex) void'(q_werr.pop_front());
         inv = ~m_act;
         chk("config_bits", ConfigBits, m_act);
         chk("config_bits_n", ConfigBits_N, inv);
         chk("wr_ready", wr_ready, !m_busy);
      end
   end

   initial begin
      logic [FBR-1:0] d2;
      logic [NCB-1:0] ones;
      logic [NCB-1:0] k21;
      ones = '1;
      k21  = {32'hFFFF_FFFF, 32'h0000_0000, 10'h3FF};

      // Reset then idle
      rst(); rst();
      mon_en = 1'b1;
      idle(); idle();
      chk("rst_cfg", ConfigBits, '0);
      chk("rst_cfg_n", ConfigBits_N, ones);
      chk("rst_wr_ready", wr_ready, 1'b1);

      // Full write then commit; done two edges after the commit sample
      wr(0, 32'hFFFF_FFFF); wr(1, 32'h0000_0000); wr(2, 32'hFFC0_0000);
      cm();
      chk("commit_done_early", commit_done, 1'b0);
      chk("wr_ready_commit", wr_ready, 1'b0);
      idle();
      chk("commit_done_edge2", commit_done, 1'b1);
      chk("cfg_pattern", ConfigBits, k21);
      idle();

      // Incomplete commit refused, then completed
      wr(0, $urandom()); wr(1, $urandom());
      cm();
      chk("commit_err_pulse", commit_err, 1'b1);
      chk("cfg_unchanged", ConfigBits, k21);
      wr(2, $urandom());
      cm(); idle(); idle();

      // Out-of-range write, readbacks
      wr(5, 32'hDEAD_BEEF);
      chk("wr_err_pulse", wr_err, 1'b1);
      for (int f = 0; f < NF; f++) begin rd(f, 1); rd(f, 0); end
      rd(5, 1);
      chk("rd_oob_zero", rd_data, '0);

      // Same-cycle write of the last frame and commit
      d2 = 32'hA5C0_0000 | 32'(($urandom() & 32'h3FF) << 22);
      wr(0, $urandom()); wr(1, $urandom());
      step(1, 2, d2, 1, 1, 2, 1, 1);
      idle();
      chk("cfg_same_cycle", ConfigBits[9:0], d2[31:22]);
      idle();

      // Reset during COMMIT aborts the copy
      rst(); idle();
      wr(0, $urandom()); wr(1, $urandom()); wr(2, $urandom());
      cm();
      rst();
      chk("abort_cfg", ConfigBits, '0);
      idle(); idle();
      chk("abort_cfg_later", ConfigBits, '0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int wf, rf;
         logic [FBR-1:0] d;
         wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 31)) : int'($urandom_range(0, 2));
         rf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 31)) : int'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0:       d = '0;
            1:       d = '1;
            default: d = $urandom();
         endcase
         step(1'($urandom_range(0, 1)), wf, d, ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1)), rf, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 199) != 0));
      end
      idle(); idle(); idle();
      @(negedge CLK);
      #2;
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shadow_config_mem.md
SHADOW_CONFIG_MEM -- requirements
Module: shadow_config_mem

Interface
REQ-001 The module SHALL have parameter MaxFramesPerCol, default 20, meaning the width of the frame index space.
REQ-002 The module SHALL have parameter FrameBitsPerRow, default 32, meaning the bits per frame.
REQ-003 The module SHALL have parameter NoConfigBits, default 74, meaning the configuration bits delivered; NFRAMES = ceil(NoConfigBits/FrameBitsPerRow), which SHALL be no greater than MaxFramesPerCol (elaboration error otherwise).
REQ-004 The module SHALL have these ports:
  CLK  in  1  single clock
  resetn  in  1  reset, synchronous and active-low
  wr_valid  in  1  frame write request
  wr_ready  out  1  frame write accept
  wr_frame  in  clog2(MaxFramesPerCol)  target frame index
  FrameData  in  FrameBitsPerRow  frame payload
  commit  in  1  request shadow-to-active copy
  commit_done  out  1  one-cycle pulse when the copy completes
  commit_err  out  1  one-cycle pulse when a commit is refused
  wr_err  out  1  one-cycle pulse on an out-of-range write
  rd_req  in  1  readback request
  rd_frame  in  clog2(MaxFramesPerCol)  readback frame index
  rd_shadow  in  1  read shadow when 1, active when 0
  rd_valid  out  1  readback data valid
  rd_data  out  FrameBitsPerRow  readback payload
  ConfigBits  out  NoConfigBits  active configuration
  ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits

Function
REQ-005 Bit mapping SHALL be: frame f, bit b maps to ConfigBits[NoConfigBits-1-(f*FrameBitsPerRow+FrameBitsPerRow-1-b)]. Frame 0 MSB is the top config bit. The last frame uses only its top bits; its unused low bits SHALL be ignored on write and read as 0.
REQ-006 A write handshake (wr_valid & wr_ready) with wr_frame < NFRAMES SHALL update the shadow frame at that edge and set written_mask[wr_frame].
REQ-007 A handshake with wr_frame >= NFRAMES SHALL leave all storage unchanged and pulse wr_err on the next cycle.
REQ-008 The FSM SHALL have states IDLE and COMMIT.
  - wr_ready = 1 in IDLE, 0 in COMMIT.
  - In IDLE, commit=1 with written_mask all ones goes to COMMIT.
  - In IDLE, commit=1 with the mask incomplete stays in IDLE and pulses commit_err next cycle.
REQ-009 In COMMIT, active SHALL receive shadow at the next edge, the mask SHALL clear, commit_done SHALL pulse for one cycle, and the FSM SHALL return to IDLE; total latency from commit sample to active update is 2 edges.
REQ-010 A write handshake and commit in the same IDLE cycle SHALL include the written frame in the commit and in the completeness check.
REQ-011 Commit asserted while in COMMIT SHALL be ignored.
REQ-012 ConfigBits SHALL change only on commit completion; ConfigBits_N SHALL always equal ~ConfigBits.
REQ-013 Readback SHALL have fixed 1-cycle latency.
  - rd_req sampled at edge N gives rd_valid=1 and rd_data after edge N.
  - An out-of-range rd_frame returns 0 with rd_valid=1.
  - Readback is accepted in both states.
REQ-014 A same-cycle write and shadow read of the same frame SHALL return the old value.

Reset
REQ-015 resetn=0 sampled at an edge SHALL clear shadow, active, written_mask, rd_data, rd_valid, commit_done, commit_err and wr_err, and set the FSM to IDLE.
REQ-016 After reset, ConfigBits SHALL be 0, ConfigBits_N all ones and wr_ready 1.
REQ-017 Reset asserted during COMMIT SHALL abort the copy, leaving active at 0.

Structure
REQ-018 A shared package SHALL hold the state enum, the NFRAMES ceiling-division function, and the bit-mapping index function.
REQ-019 One sub-module, config_frame_slice (one frame of shadow plus active registers with masked load), SHALL be instantiated NFRAMES times.

Verification
REQ-020 Reset then idle: ConfigBits=0, ConfigBits_N=all ones, wr_ready=1, no pulses.
REQ-021 Defaults; write frame0=0xFFFFFFFF, frame1=0x00000000, frame2=0xFFC00000; commit:
  - ConfigBits[73:42] all ones, ConfigBits[41:10]=0, ConfigBits[9:0] all ones.
  - commit_done pulses exactly 2 edges after commit.
REQ-022 Write frames 0 and 1 only, then commit:
  - commit_err pulses and ConfigBits is unchanged.
  - Write frame 2, commit: succeeds.
REQ-023 Write wr_frame=5: wr_err pulses, readback of frames 0-2 is unchanged, and shadow readback of frame 5 returns 0.
REQ-024 Write frame 2 and assert commit in the same cycle (frames 0-1 already written): commit succeeds and frame 2 data appears on ConfigBits[9:0].
REQ-025 Assert resetn=0 in the COMMIT cycle: ConfigBits stays 0 and commit_done never pulses.
